// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/acknowledge bus between the fetch stage and a
// variable-latency instruction memory.
//
//   imem_req    master->slave  request; held until acknowledged
//   imem_addr   master->slave  word address; stable while imem_req=1
//   imem_ack    slave->master  completion; imem_rdata valid in the same cycle
//   imem_rdata  slave->master  fetched word
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, issues one request at a time to the
// instruction memory, presents the pc/instruction pair to IF/ID and emits a
// NOP bubble whenever no valid instruction is available. Taken branches
// redirect the PC; data belonging to the wrong path is discarded.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   stall_i          hazard stall; only honoured while an instruction is valid
//   branch_i         taken-branch redirect pulse
//   branch_target_i  redirect address (bits [1:0] forced to zero)
//   imem             instruction-memory bus (master side)
//   pc_o             address of instruction_o
//   instruction_o    fetched instruction, or NOP_WORD when valid_o=0
//   valid_o          instruction_o holds a real fetched instruction
//   flush_o          IF/ID flush, combinationally equal to branch_i
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   branch_i,
    input  logic [31:0]            branch_target_i,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            pc_o,
    output logic [31:0]            instruction_o,
    output logic                   valid_o,
    output logic                   flush_o
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_VALID = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_instr_buf;
    logic [1:0]  r_state;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_req_addr_nxt;
    logic [31:0] w_instr_buf_nxt;
    logic [1:0]  w_state_nxt;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic        w_req;
    logic        w_ack;
    logic        w_valid;

    assign w_target = {branch_target_i[31:2], 2'b00};
    assign w_pc_inc = r_req_addr + 32'd4;

    // A request is outstanding in S_REQ and S_DRAIN; ack only counts then.
    assign w_req   = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign w_ack   = w_req && imem.imem_ack;
    assign w_valid = (r_state == S_VALID);

    always_comb begin
        w_pc_nxt        = r_pc;
        w_req_addr_nxt  = r_req_addr;
        w_instr_buf_nxt = r_instr_buf;
        w_state_nxt     = r_state;

        case (r_state)
            S_REQ: begin
                if (branch_i) begin
                    w_pc_nxt = w_target;
                    if (w_ack) begin
                        // Request completed this cycle: drop the data and
                        // start the target fetch right away.
                        w_req_addr_nxt = w_target;
                        w_state_nxt    = S_REQ;
                    end else begin
                        // Request still in flight: keep its address on the bus
                        // until the memory answers, then re-issue from r_pc.
                        w_state_nxt = S_DRAIN;
                    end
                end else if (w_ack) begin
                    w_instr_buf_nxt = imem.imem_rdata;
                    w_state_nxt     = S_VALID;
                end
            end

            S_VALID: begin
                if (branch_i) begin
                    w_pc_nxt       = w_target;
                    w_req_addr_nxt = w_target;
                    w_state_nxt    = S_REQ;
                end else if (!stall_i) begin
                    w_pc_nxt       = w_pc_inc;
                    w_req_addr_nxt = w_pc_inc;
                    w_state_nxt    = S_REQ;
                end
            end

            S_DRAIN: begin
                if (branch_i) begin
                    w_pc_nxt = w_target;
                end
                if (w_ack) begin
                    // A branch landing on the draining ack still wins.
                    w_req_addr_nxt = branch_i ? w_target : r_pc;
                    w_state_nxt    = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_instr_buf <= NOP_WORD;
            r_state     <= S_REQ;
        end else begin
            r_pc        <= w_pc_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_instr_buf <= w_instr_buf_nxt;
            r_state     <= w_state_nxt;
        end
    end

    // Reset forces the visible outputs immediately, abandoning any request.
    assign imem.imem_req  = w_req && !rst_i;
    assign imem.imem_addr = r_req_addr;

    assign valid_o       = w_valid && !rst_i;
    assign instruction_o = valid_o ? r_instr_buf : NOP_WORD;
    assign pc_o          = rst_i ? RESET_PC : r_req_addr;
    assign flush_o       = branch_i;

    // Bus protocol: address held while an unanswered request stays up.
    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (imem.imem_req && !imem.imem_ack) |=>
            (imem.imem_req && (imem.imem_addr == $past(imem.imem_addr))));

    a_req_valid_excl: assert property (@(posedge clk_i)
        !(imem.imem_req && valid_o));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        valid_o;
    logic        flush_o;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    if_fetch_unit_if u_if ();

    if_fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_WORD (32'h0000_0000)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .imem            (u_if.master),
        .pc_o            (pc_o),
        .instruction_o   (instruction_o),
        .valid_o         (valid_o),
        .flush_o         (flush_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents: word at address a is a ^ DEAD0000 (never zero here).
    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Entered in the first request cycle for addr; leaves in the S_VALID cycle.
    task automatic fetch_ok(input logic [31:0] addr);
        check("req_first", 32'(u_if.imem_req), 32'd1);
        check("addr_first", u_if.imem_addr, addr);
        check("valid_wait", 32'(valid_o), 32'd0);
        check("nop_wait", instruction_o, 32'd0);
        u_if.imem_ack = 1'b0;
        step();
        check("addr_second", u_if.imem_addr, addr);
        u_if.imem_ack   = 1'b1;
        u_if.imem_rdata = memw(addr);
        step();
        u_if.imem_ack   = 1'b0;
        u_if.imem_rdata = 32'h0;
        check("valid", 32'(valid_o), 32'd1);
        check("pc", pc_o, addr);
        check("instr", instruction_o, memw(addr));
        check("req_idle", 32'(u_if.imem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i           = 1'b1;
        stall_i         = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = 32'h0;
        u_if.imem_ack   = 1'b0;
        u_if.imem_rdata = 32'h0;

        // Reset state
        step();
        step();
        check("rst_req", 32'(u_if.imem_req), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instruction_o, 32'd0);
        check("rst_pc", pc_o, RST_PC);

        // Sequential fetch 0x100, 0x104
        rst_i = 1'b0;
        #1;
        fetch_ok(32'h100);
        step();
        fetch_ok(32'h104);

        // Stall for 3 cycles while valid at 0x104
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(valid_o), 32'd1);
            check("stall_pc", pc_o, 32'h104);
            check("stall_instr", instruction_o, memw(32'h104));
            check("stall_noreq", 32'(u_if.imem_req), 32'd0);
        end
        stall_i = 1'b0;
        step();
        check("after_stall_addr", u_if.imem_addr, 32'h108);

        // Branch while waiting on 0x108 (no ack): drain, then go to 0x2000
        branch_i        = 1'b1;
        branch_target_i = 32'h2003;
        #1;
        check("flush_hi", 32'(flush_o), 32'd1);
        step();
        branch_i = 1'b0;
        #1;
        check("flush_lo", 32'(flush_o), 32'd0);
        check("drain_req", 32'(u_if.imem_req), 32'd1);
        check("drain_addr", u_if.imem_addr, 32'h108);
        step();
        check("drain_addr2", u_if.imem_addr, 32'h108);
        u_if.imem_ack   = 1'b1;
        u_if.imem_rdata = memw(32'h108);
        step();
        u_if.imem_ack   = 1'b0;
        check("drain_dropped_valid", 32'(valid_o), 32'd0);
        check("drain_dropped_instr", instruction_o, 32'd0);
        fetch_ok(32'h2000);

        // Branch and stall together in S_VALID: branch wins
        branch_i        = 1'b1;
        branch_target_i = 32'h3000;
        stall_i         = 1'b1;
        step();
        branch_i = 1'b0;
        stall_i  = 1'b0;
        check("bs_valid", 32'(valid_o), 32'd0);
        check("bs_req", 32'(u_if.imem_req), 32'd1);
        check("bs_addr", u_if.imem_addr, 32'h3000);
        step();

        // Branch and ack in the same cycle: data dropped, target next
        branch_i        = 1'b1;
        branch_target_i = 32'h4000;
        u_if.imem_ack   = 1'b1;
        u_if.imem_rdata = memw(32'h3000);
        step();
        branch_i      = 1'b0;
        u_if.imem_ack = 1'b0;
        check("ba_valid", 32'(valid_o), 32'd0);
        fetch_ok(32'h4000);

        // PC wrap from 0xFFFFFFFC
        branch_i        = 1'b1;
        branch_target_i = 32'hFFFF_FFFE;
        step();
        branch_i = 1'b0;
        fetch_ok(32'hFFFF_FFFC);
        step();
        check("wrap_addr", u_if.imem_addr, 32'h0);
        check("wrap_req", 32'(u_if.imem_req), 32'd1);

        // Reset during an outstanding request
        step();
        rst_i = 1'b1;
        #1;
        check("midrst_req", 32'(u_if.imem_req), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_pc", pc_o, RST_PC);
        step();
        rst_i = 1'b0;
        #1;
        fetch_ok(RST_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
